// File: rtl/ac_ram_bridge_pkg.sv
// Shared types and helpers for the Arcade Card RAM bridge: FSM states, the
// queued access record and byte-lane helpers.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } ac_st_t;

  typedef struct packed {
    logic        we;
    logic [20:0] a;
    logic [7:0]  d;
  } ac_req_t;

  localparam logic [7:0] DO_RST = 8'hFF;

  // Odd byte addresses live in the upper half of the 16-bit word.
  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic a0);
    return a0 ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [1:0] wr_be(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ac_ram_bridge_if.sv
// Word-memory request/acknowledge bus between the bridge and the SDRAM arbiter.
interface ac_ram_bridge_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [19:0] MEM_A;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_D;
  logic [15:0] MEM_Q;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_A, MEM_BE, MEM_D,
    input  MEM_Q, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_A, MEM_BE, MEM_D,
    output MEM_Q, MEM_ACK
  );
endinterface

// File: rtl/ac_ram_bridge_word_buf.sv
// One-word read buffer: tag/valid/data with lookup, write-byte merge and invalidate.
// Lookups see a fill happening on the same edge, so a dequeued access hits fresh data.
module ac_word_buf
  import ac_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inval,
  input  logic        fill_en,
  input  logic [19:0] fill_tag,
  input  logic [15:0] fill_data,
  input  logic [20:0] look_a,
  input  logic        merge_en,
  input  logic [7:0]  merge_d,
  output logic        hit,
  output logic [7:0]  rd_byte
);

  logic        valid;
  logic [19:0] tag;
  logic [15:0] data;

  logic        valid_v;
  logic [19:0] tag_v;
  logic [15:0] data_v;
  logic [15:0] merged;
  logic        merge_hit;

  always_comb begin
    valid_v   = fill_en ? 1'b1 : valid;
    tag_v     = fill_en ? fill_tag : tag;
    data_v    = fill_en ? fill_data : data;
    hit       = ENABLE && valid_v && (tag_v == look_a[20:1]);
    rd_byte   = sel_byte(data_v, look_a[0]);
    merge_hit = merge_en && hit;
    merged    = look_a[0] ? {merge_d, data_v[7:0]} : {data_v[15:8], merge_d};
  end

  // A fill beats a simultaneous invalidate.
  always_ff @(posedge clk) begin
    if (rst)          valid <= 1'b0;
    else if (fill_en) valid <= 1'b1;
    else if (inval)   valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag <= fill_tag;
    if (fill_en || merge_hit) data <= merge_hit ? merged : data_v;
  end

endmodule

// File: rtl/ac_ram_bridge.sv
// Arcade Card RAM window responder: turns CPU byte strobes into 16-bit word
// memory requests with a read buffer, posted writes and a one-entry queue.
module ac_ram_bridge
  import ac_pkg::*;
#(
  parameter int USE_WORD_BUF = 1,
  parameter int TIMEOUT      = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CS_N,
  input  logic [20:0]    A,
  input  logic           WR_N,
  input  logic           RD_N,
  input  logic [7:0]     DI,
  output logic [7:0]     DO,
  output logic           BUSY,
  input  logic           INVAL,
  output logic           ERR,
  ac_ram_bridge_if.master mem
);

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  ac_st_t        state, state_n;
  logic          req, req_n;
  logic          we, we_n;
  logic [1:0]    be, be_n;
  logic [19:0]   mem_a, mem_a_n;
  logic [15:0]   mem_d, mem_d_n;
  logic [7:0]    do_r, do_n;
  logic          err, err_n;
  logic [20:0]   cur_a, cur_a_n;
  logic          q_full, q_full_n;
  ac_req_t       q, q_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          old_acc;

  logic          acc, ev, busy_st, ack_in, abandon, done, fill_en, start, merge_en;
  ac_req_t       ev_req, nxt;
  logic          hit;
  logic [7:0]    rd_byte;

  ac_word_buf #(.ENABLE(USE_WORD_BUF != 0)) u_buf (
    .clk       (CLK),
    .rst       (RST),
    .inval     (INVAL),
    .fill_en   (fill_en),
    .fill_tag  (cur_a[20:1]),
    .fill_data (mem.MEM_Q),
    .look_a    (nxt.a),
    .merge_en  (merge_en),
    .merge_d   (nxt.d),
    .hit       (hit),
    .rd_byte   (rd_byte)
  );

  // Event detect, completion and choice of the access to start this edge.
  always_comb begin
    acc      = ~(WR_N & RD_N);
    ev       = acc & ~old_acc & ~CS_N;
    ev_req   = '{we: ~WR_N, a: A, d: DI};
    busy_st  = (state == RD_WAIT) || (state == WR_WAIT);
    ack_in   = busy_st & mem.MEM_ACK;
    abandon  = busy_st & ~mem.MEM_ACK & TO_EN & (tcnt == T_LAST);
    done     = ack_in | abandon;
    fill_en  = (state == RD_WAIT) & ack_in;
    start    = 1'b0;
    nxt      = ev_req;
    q_full_n = q_full;
    q_n      = q;
    if (!busy_st) begin
      start = ev;
    end else if (done) begin
      if (q_full) begin
        start    = 1'b1;
        nxt      = q;
        q_full_n = ev;
        q_n      = ev_req;
      end else begin
        start = ev;
      end
    end else if (ev && !q_full) begin
      q_full_n = 1'b1;
      q_n      = ev_req;
    end
    merge_en = start & nxt.we;
  end

  // Next-state and request outputs.
  always_comb begin
    state_n = state;
    req_n   = req;
    we_n    = we;
    be_n    = be;
    mem_a_n = mem_a;
    mem_d_n = mem_d;
    do_n    = do_r;
    err_n   = abandon;
    cur_a_n = cur_a;
    tcnt_n  = tcnt + 1'b1;

    if (done) begin
      req_n   = 1'b0;
      state_n = IDLE;
      if (state == RD_WAIT) do_n = ack_in ? sel_byte(mem.MEM_Q, cur_a[0]) : DO_RST;
    end

    if (start) begin
      cur_a_n = nxt.a;
      tcnt_n  = '0;
      if (nxt.we) begin
        req_n   = 1'b1;
        we_n    = 1'b1;
        be_n    = wr_be(nxt.a[0]);
        mem_a_n = nxt.a[20:1];
        mem_d_n = {nxt.d, nxt.d};
        state_n = WR_WAIT;
      end else if (hit) begin
        do_n    = rd_byte;
        state_n = IDLE;
      end else begin
        req_n   = 1'b1;
        we_n    = 1'b0;
        be_n    = 2'b11;
        mem_a_n = nxt.a[20:1];
        state_n = RD_WAIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    old_acc <= acc;
    if (RST) begin
      state  <= IDLE;
      req    <= 1'b0;
      we     <= 1'b0;
      be     <= 2'b00;
      do_r   <= DO_RST;
      err    <= 1'b0;
      q_full <= 1'b0;
    end else begin
      state  <= state_n;
      req    <= req_n;
      we     <= we_n;
      be     <= be_n;
      do_r   <= do_n;
      err    <= err_n;
      q_full <= q_full_n;
    end
  end

  always_ff @(posedge CLK) begin
    mem_a <= mem_a_n;
    mem_d <= mem_d_n;
    cur_a <= cur_a_n;
    q     <= q_n;
    tcnt  <= tcnt_n;
  end

  assign mem.MEM_REQ = req;
  assign mem.MEM_WE  = we;
  assign mem.MEM_A   = mem_a;
  assign mem.MEM_BE  = be;
  assign mem.MEM_D   = mem_d;
  assign DO          = do_r;
  assign ERR         = err;
  assign BUSY        = (state == RD_WAIT) | q_full;

endmodule

// File: tb/tb_ac_ram_bridge.sv
// Directed bench for ac_ram_bridge: buffer hits/misses, posted writes, queueing,
// invalidate, reset mid-request and request timeout.
module tb_ac_ram_bridge;

  logic        CLK = 1'b0;
  logic        RST, CS_N, WR_N, RD_N, INVAL;
  logic [20:0] A;
  logic [7:0]  DI, DO;
  logic        BUSY, ERR;
  int          n_cmp = 0;
  int          n_bad = 0;

  ac_ram_bridge_if mif();

  ac_ram_bridge #(.USE_WORD_BUF(1), .TIMEOUT(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .CS_N  (CS_N),
    .A     (A),
    .WR_N  (WR_N),
    .RD_N  (RD_N),
    .DI    (DI),
    .DO    (DO),
    .BUSY  (BUSY),
    .INVAL (INVAL),
    .ERR   (ERR),
    .mem   (mif)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic access(input logic w, input logic [20:0] a, input logic [7:0] d);
    CS_N = 1'b0;
    A    = a;
    DI   = d;
    if (w) WR_N = 1'b0;
    else   RD_N = 1'b0;
    tick();
    WR_N = 1'b1;
    RD_N = 1'b1;
    CS_N = 1'b1;
    tick();
  endtask

  task automatic ack(input logic [15:0] qv);
    mif.MEM_ACK = 1'b1;
    mif.MEM_Q   = qv;
    tick();
    mif.MEM_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    int errs;
    RST = 1'b1; CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; INVAL = 1'b0;
    A = '0; DI = '0; mif.MEM_ACK = 1'b0; mif.MEM_Q = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_do",   DO, 8'hFF);
    check("rst_busy", BUSY, 0);
    check("rst_err",  ERR, 0);
    check("rst_req",  mif.MEM_REQ, 0);
    check("rst_we",   mif.MEM_WE, 0);
    check("rst_be",   mif.MEM_BE, 0);

    // read miss at byte 0x00001
    access(1'b0, 21'h00001, 8'h00);
    check("miss_req",  mif.MEM_REQ, 1);
    check("miss_a",    mif.MEM_A, 20'h00000);
    check("miss_be",   mif.MEM_BE, 2'b11);
    check("miss_we",   mif.MEM_WE, 0);
    check("miss_busy", BUSY, 1);
    tick();
    check("miss_busy2", BUSY, 1);
    ack(16'hBEEF);
    check("miss_req_drop", mif.MEM_REQ, 0);
    check("miss_busy_rel", BUSY, 0);
    check("miss_do",       DO, 8'hBE);

    // hit on the other byte of the same word
    access(1'b0, 21'h00000, 8'h00);
    check("hit_do",  DO, 8'hEF);
    check("hit_req", mif.MEM_REQ, 0);

    // posted write that merges into the buffer
    access(1'b1, 21'h00000, 8'h5A);
    check("wr_req",  mif.MEM_REQ, 1);
    check("wr_we",   mif.MEM_WE, 1);
    check("wr_be",   mif.MEM_BE, 2'b01);
    check("wr_d",    mif.MEM_D, 16'h5A5A);
    check("wr_busy", BUSY, 0);
    check("wr_do",   DO, 8'hEF);
    ack(16'h0000);
    check("wr_req_drop", mif.MEM_REQ, 0);
    access(1'b0, 21'h00000, 8'h00);
    check("merge_do",  DO, 8'h5A);
    check("merge_req", mif.MEM_REQ, 0);

    // write then read queued behind it
    access(1'b1, 21'h00010, 8'h33);
    check("qw_a",  mif.MEM_A, 20'h00008);
    check("qw_be", mif.MEM_BE, 2'b01);
    access(1'b0, 21'h00020, 8'h00);
    check("q_busy", BUSY, 1);
    check("q_a_stable",  mif.MEM_A, 20'h00008);
    check("q_we_stable", mif.MEM_WE, 1);
    ack(16'h0000);
    check("q_req_next", mif.MEM_REQ, 1);
    check("q_we_rd",    mif.MEM_WE, 0);
    check("q_a_rd",     mif.MEM_A, 20'h00010);
    check("q_be_rd",    mif.MEM_BE, 2'b11);
    check("q_busy_rd",  BUSY, 1);
    ack(16'h1234);
    check("q_do",      DO, 8'h34);
    check("q_busy_end", BUSY, 0);

    // hit, invalidate, then the same word misses
    access(1'b0, 21'h00021, 8'h00);
    check("inv_hit_do",  DO, 8'h12);
    check("inv_hit_req", mif.MEM_REQ, 0);
    INVAL = 1'b1;
    tick();
    INVAL = 1'b0;
    access(1'b0, 21'h00020, 8'h00);
    check("inv_miss_req", mif.MEM_REQ, 1);
    ack(16'hCAFE);
    check("inv_do", DO, 8'hFE);

    // reset during a pending read
    access(1'b0, 21'h00000, 8'h00);
    check("rr_req", mif.MEM_REQ, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rr_req_drop", mif.MEM_REQ, 0);
    check("rr_do",       DO, 8'hFF);
    check("rr_busy",     BUSY, 0);
    check("rr_be",       mif.MEM_BE, 0);
    ack(16'h7777);
    check("late_ack_req", mif.MEM_REQ, 0);
    check("late_ack_do",  DO, 8'hFF);
    access(1'b0, 21'h00020, 8'h00);
    check("rr_buf_inval", mif.MEM_REQ, 1);
    ack(16'h5555);
    check("rr_do2", DO, 8'h55);

    // timeout on an unanswered read
    access(1'b0, 21'h00040, 8'h00);
    n = 1;
    errs = 0;
    while (mif.MEM_REQ && n < 20) begin
      tick();
      n++;
      if (ERR) errs++;
    end
    check("to_cycles", n, 8);
    tick();
    if (ERR) errs++;
    check("to_err_pulses", errs, 1);
    check("to_do",   DO, 8'hFF);
    check("to_busy", BUSY, 0);
    check("to_req",  mif.MEM_REQ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
